// File: rtl/ppb_probe_phy_if.sv
// rtl/ppb_probe_phy_if.sv - PMod Probe Bus pin bundle between probe PHY and target PHY
// Purpose: groups the four PMod Probe Bus pins so the probe PHY and the board/bench share one bundle.
// Ports (signals):
//   pmod_bus_clk      bus clock, generated by the probe
//   pmod_bus_control  ack / frame-start marker, probe to target
//   pmod_bus_poti     3-bit probe-to-target data
//   pmod_bus_pito     3-bit target-to-probe data
// Modports: master = probe side, slave = target side.
interface ppb_probe_phy_if;
   logic       pmod_bus_clk;
   logic       pmod_bus_control;
   logic [2:0] pmod_bus_poti;
   logic [2:0] pmod_bus_pito;

   modport master (
      output pmod_bus_clk,
      output pmod_bus_control,
      output pmod_bus_poti,
      input  pmod_bus_pito
   );

   modport slave (
      input  pmod_bus_clk,
      input  pmod_bus_control,
      input  pmod_bus_poti,
      output pmod_bus_pito
   );
endinterface

// File: rtl/ppb_probe_phy.sv
// rtl/ppb_probe_phy.sv - probe-side PMod Probe Bus PHY: clock generation, init reception, framing
// Purpose: generates the bus clock, receives the target's comm-init sequence, acknowledges it and then
//          exchanges 3-bit blocks with the target every bus cycle in continuous frames.
// Ports:
//   clk, rst           system clock, synchronous active-low reset
//   bus (master)       pmod_bus_clk / pmod_bus_control / pmod_bus_poti out, pmod_bus_pito in
//   probe_inputs       blocks sent to target, block k = bits [MAX_BLOCKS*3-1-3k -: 3]
//   probe_outputs      blocks received from target, same layout; updated with frame_valid
//   frame_valid        1-clk pulse when probe_outputs updated
//   project_id         received 24-bit project ID
//   in_blocks          received target input-block count
//   out_blocks         received target output-block count
//   link_up            high in ACTIVE
//   init_fail          1-clk pulse on a rejected init sequence
//   link_state         state encoding (IDLE=0 SETTLE=1 SEARCH=2 RX_INIT=3 ACK=4 ACTIVE=5)
// Optional feature macro: PPB_PROBE_ID_CHECK_EN (init also requires project_id == EXPECTED_PROJECT_ID).
module ppb_probe_phy #(
   parameter int unsigned CLK_DIV             = 4,
   parameter int unsigned SETTLE_CYCLES       = 40,
   parameter int unsigned MAX_BLOCKS          = 16,
   parameter logic [23:0] EXPECTED_PROJECT_ID = 24'h000000
) (
   input  logic                      clk,
   input  logic                      rst,
   ppb_probe_phy_if.master           bus,
   input  logic [MAX_BLOCKS*3-1:0]   probe_inputs,
   output logic [MAX_BLOCKS*3-1:0]   probe_outputs,
   output logic                      frame_valid,
   output logic [23:0]               project_id,
   output logic [8:0]                in_blocks,
   output logic [8:0]                out_blocks,
   output logic                      link_up,
   output logic                      init_fail,
   output logic [3:0]                link_state
);
   localparam int unsigned DW = $clog2(CLK_DIV);
   localparam int unsigned IW = $clog2(MAX_BLOCKS);
   localparam logic [8:0]  MAXB = 9'(MAX_BLOCKS);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0, S_SETTLE = 4'd1, S_SEARCH = 4'd2,
      S_RX_INIT = 4'd3, S_ACK = 4'd4, S_ACTIVE = 4'd5
   } state_t;

`ifndef PPB_PROBE_ID_CHECK_EN
   localparam logic [23:0] unused_expected_id = EXPECTED_PROJECT_ID;
`endif

   function automatic logic [2:0] rev3(input logic [2:0] v);
      return {v[0], v[1], v[2]};
   endfunction

   state_t          state_q, state_d;
   logic [DW-1:0]   div_q, div_d;
   logic            bclk_q, bclk_d;
   logic            ctrl_q, ctrl_d;
   logic [2:0]      poti_q, poti_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [23:0]     pid_q, pid_d;
   logic [8:0]      ib_q, ib_d, ob_q, ob_d;
   logic [IW-1:0]   b_q, b_d, bprev_q, bprev_d;
   logic            disc_q, disc_d;
   logic            fv_q, fv_d, fail_q, fail_d;
   logic [2:0]      sh_in_q  [MAX_BLOCKS];
   logic [2:0]      sh_in_d  [MAX_BLOCKS];
   logic [2:0]      sh_out_q [MAX_BLOCKS];
   logic [2:0]      sh_out_d [MAX_BLOCKS];
   logic [2:0]      pout_q   [MAX_BLOCKS];
   logic [2:0]      pout_d   [MAX_BLOCKS];
   logic [2:0]      pin_blk  [MAX_BLOCKS];

   logic            fall_evt, ok;
   logic [2:0]      blk;
   logic [8:0]      nblk_m1;
   logic [IW-1:0]   b_nxt;

   for (genvar k = 0; k < MAX_BLOCKS; k++) begin : g_blk
      assign pin_blk[k] = probe_inputs[MAX_BLOCKS*3-1-3*k -: 3];
      assign probe_outputs[MAX_BLOCKS*3-1-3*k -: 3] = pout_q[k];
   end

   // Frame length minus one; counts are validated nonzero before ACTIVE.
   assign nblk_m1 = ((ib_q > ob_q) ? ib_q : ob_q) - 9'd1;
   assign b_nxt   = (9'(b_q) == nblk_m1) ? '0 : b_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bclk_d   = bclk_q;
      ctrl_d   = ctrl_q;
      poti_d   = poti_q;
      cnt_d    = cnt_q;
      pid_d    = pid_q;
      ib_d     = ib_q;
      ob_d     = ob_q;
      b_d      = b_q;
      bprev_d  = bprev_q;
      disc_d   = disc_q;
      fv_d     = 1'b0;
      fail_d   = 1'b0;
      sh_in_d  = sh_in_q;
      sh_out_d = sh_out_q;
      pout_d   = pout_q;
      fall_evt = 1'b0;
      ok       = 1'b0;
      blk      = 3'b000;

      if (state_q == S_IDLE) begin
         div_d   = '0;
         bclk_d  = 1'b0;
         cnt_d   = '0;
         state_d = S_SETTLE;
      end else if (div_q == DW'(CLK_DIV - 1)) begin
         div_d    = '0;
         bclk_d   = ~bclk_q;
         fall_evt = bclk_q;
      end else begin
         div_d = div_q + 1'b1;
      end

      // The target acts on rising edges, so everything probe-side moves on the falling edge.
      if (fall_evt) begin
         case (state_q)
            S_SETTLE: begin
               if (cnt_q == 6'(SETTLE_CYCLES - 1)) begin
                  cnt_d   = '0;
                  state_d = S_SEARCH;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
            S_SEARCH: begin
               if (bus.pmod_bus_pito == 3'b111) begin
                  cnt_d   = '0;
                  state_d = S_RX_INIT;
               end
            end
            S_RX_INIT: begin
               cnt_d = cnt_q + 6'd1;
               if (cnt_q < 6'd8)       pid_d = {pid_q[20:0], bus.pmod_bus_pito};
               else if (cnt_q < 6'd11) ib_d  = {ib_q[5:0], bus.pmod_bus_pito};
               else                    ob_d  = {ob_q[5:0], bus.pmod_bus_pito};
               if (cnt_q == 6'd13) begin
                  ok = (ib_q != 9'd0) && (ib_q <= MAXB) && (ob_d != 9'd0) && (ob_d <= MAXB);
`ifdef PPB_PROBE_ID_CHECK_EN
                  ok = ok && (pid_q == EXPECTED_PROJECT_ID);
`endif
                  if (ok) begin
                     state_d = S_ACK;
                  end else begin
                     fail_d  = 1'b1;
                     state_d = S_SEARCH;
                  end
               end
            end
            S_ACK: begin
               // The ack slot acts as block 0 of a throw-away frame, so control stays high a
               // single bus cycle and the first real frame marker lands N cycles later.
               ctrl_d  = 1'b1;
               poti_d  = 3'b000;
               sh_in_d = pin_blk;
               bprev_d = '0;
               b_d     = (nblk_m1 == 9'd0) ? '0 : IW'(1);
               disc_d  = 1'b1;
               state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
               ctrl_d = (b_q == '0);
               if (b_q == '0) sh_in_d = pin_blk;
               blk    = sh_in_d[b_q];
               poti_d = (9'(b_q) < ib_q) ? rev3(blk) : 3'b000;
               // pito now carries the target's answer to the block driven one bus cycle ago.
               if (9'(bprev_q) < ob_q) sh_out_d[bprev_q] = rev3(bus.pmod_bus_pito);
               if (9'(bprev_q) == nblk_m1) begin
                  if (disc_q) begin
                     disc_d = 1'b0;
                  end else begin
                     fv_d = 1'b1;
                     for (int k = 0; k < MAX_BLOCKS; k++)
                        pout_d[k] = (9'(k) < ob_q) ? sh_out_d[k] : 3'b000;
                  end
               end
               bprev_d = b_q;
               b_d     = b_nxt;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         bclk_q  <= 1'b0;
         ctrl_q  <= 1'b0;
         poti_q  <= 3'b000;
         cnt_q   <= '0;
         pid_q   <= '0;
         ib_q    <= '0;
         ob_q    <= '0;
         b_q     <= '0;
         bprev_q <= '0;
         disc_q  <= 1'b0;
         fv_q    <= 1'b0;
         fail_q  <= 1'b0;
         for (int k = 0; k < MAX_BLOCKS; k++) begin
            sh_in_q[k]  <= 3'b000;
            sh_out_q[k] <= 3'b000;
            pout_q[k]   <= 3'b000;
         end
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bclk_q   <= bclk_d;
         ctrl_q   <= ctrl_d;
         poti_q   <= poti_d;
         cnt_q    <= cnt_d;
         pid_q    <= pid_d;
         ib_q     <= ib_d;
         ob_q     <= ob_d;
         b_q      <= b_d;
         bprev_q  <= bprev_d;
         disc_q   <= disc_d;
         fv_q     <= fv_d;
         fail_q   <= fail_d;
         sh_in_q  <= sh_in_d;
         sh_out_q <= sh_out_d;
         pout_q   <= pout_d;
      end
   end

   assign bus.pmod_bus_clk     = bclk_q;
   assign bus.pmod_bus_control = ctrl_q;
   assign bus.pmod_bus_poti    = poti_q;
   assign frame_valid          = fv_q;
   assign project_id           = pid_q;
   assign in_blocks            = ib_q;
   assign out_blocks           = ob_q;
   assign init_fail            = fail_q;
   assign link_up              = (state_q == S_ACTIVE);
   assign link_state           = state_q;
endmodule

// File: tb/tb_ppb_probe_phy.sv
// tb/tb_ppb_probe_phy.sv - directed self-checking bench for ppb_probe_phy with a target PHY model
module tb_ppb_probe_phy;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [47:0] probe_inputs;
   logic [47:0] probe_outputs;
   logic        frame_valid, link_up, init_fail;
   logic [23:0] project_id;
   logic [8:0]  in_blocks, out_blocks;
   logic [3:0]  link_state;

   int n_vec = 0;
   int n_err = 0;

   ppb_probe_phy_if bus_if ();

   ppb_probe_phy #(
      .CLK_DIV(2), .SETTLE_CYCLES(8), .MAX_BLOCKS(16), .EXPECTED_PROJECT_ID(24'h123456)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus_if),
      .probe_inputs(probe_inputs), .probe_outputs(probe_outputs),
      .frame_valid(frame_valid), .project_id(project_id),
      .in_blocks(in_blocks), .out_blocks(out_blocks),
      .link_up(link_up), .init_fail(init_fail), .link_state(link_state)
   );

   always #5 clk = ~clk;

   // Target PHY model: words queued by the bench go out first, then it waits for the ack and
   // runs frames, resyncing its block index on every control-marked rising edge.
   logic [2:0] t_q [$];
   logic [2:0] t_dev [16];
   logic [2:0] t_rx  [16];
   int t_ib, t_ob, t_n, t_idx, t_since, t_since_ctrl, t_ctrl_gap, t_ack_gap, ctrl_cnt;
   bit t_armed, t_active, t_poti_nz;

   function automatic logic [2:0] rev3(input logic [2:0] v);
      return {v[0], v[1], v[2]};
   endfunction

   always @(posedge bus_if.pmod_bus_clk) begin
      if (t_q.size() != 0) begin
         bus_if.pmod_bus_pito <= t_q.pop_front();
         t_since   = 0;
         t_armed   = 1'b1;
         t_active  = 1'b0;
         t_poti_nz = 1'b0;
      end else begin
         t_since++;
         t_since_ctrl++;
         if (bus_if.pmod_bus_control) begin
            ctrl_cnt++;
            t_ctrl_gap   = t_since_ctrl;
            t_since_ctrl = 0;
            t_idx        = 0;
            if (t_armed) begin
               t_armed   = 1'b0;
               t_active  = 1'b1;
               t_ack_gap = t_since;
            end
         end else if (t_active) begin
            if (t_since_ctrl > t_n) t_active = 1'b0;
            else t_idx = (t_idx + 1 >= t_n) ? 0 : t_idx + 1;
         end
         if (t_active) begin
            if (t_idx < t_ib) t_rx[t_idx] = rev3(bus_if.pmod_bus_poti);
            else if (bus_if.pmod_bus_poti != 3'b000) t_poti_nz = 1'b1;
            bus_if.pmod_bus_pito <= (t_idx < t_ob) ? rev3(t_dev[t_idx]) : 3'b000;
         end else begin
            bus_if.pmod_bus_pito <= 3'b000;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic sel(input int w);
      case (w)
         0: sel = bus_if.pmod_bus_clk;
         1: sel = bus_if.pmod_bus_control;
         2: sel = frame_valid;
         3: sel = init_fail;
         4: sel = link_up;
         default: sel = (link_state == 4'd2);
      endcase
   endfunction

   // Clock cycles until the selected signal goes 0->1, or -1 when the budget runs out.
   task automatic wait_rise(input int w, input int maxc, output int cyc);
      logic prev;
      prev = sel(w);
      cyc  = -1;
      for (int i = 1; i <= maxc; i++) begin
         @(posedge clk); #1;
         if (sel(w) && !prev) begin
            cyc = i;
            break;
         end
         prev = sel(w);
      end
   endtask

   task automatic push_init(input logic [23:0] id, input int ib, input int ob);
      logic [8:0] ibv, obv;
      ibv  = 9'(ib);
      obv  = 9'(ob);
      t_ib = ib;
      t_ob = ob;
      t_n  = (ib > ob) ? ib : ob;
      t_q.push_back(3'b111);
      for (int i = 0; i < 8; i++) t_q.push_back(id[23-3*i -: 3]);
      for (int i = 0; i < 3; i++) t_q.push_back(ibv[8-3*i -: 3]);
      for (int i = 0; i < 3; i++) t_q.push_back(obv[8-3*i -: 3]);
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      int cyc, c0;
      logic [23:0] exp_id;
      probe_inputs = {12'o1234, 36'o777777777777};
      t_dev[0] = 3'o7; t_dev[1] = 3'o6; t_dev[2] = 3'o5; t_dev[3] = 3'o4; t_dev[4] = 3'o3;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busclk", bus_if.pmod_bus_clk, 1'b0);
      check("rst_control", bus_if.pmod_bus_control, 1'b0);
      check("rst_poti", bus_if.pmod_bus_poti, 3'b000);
      check("rst_state", link_state, 4'd0);
      check("rst_outputs", probe_outputs, 48'h0);
      check("rst_misc", {frame_valid, link_up, init_fail, project_id, in_blocks, out_blocks}, 45'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("idle_to_settle", link_state, 4'd1);

      // Bus clock period: 2*CLK_DIV clk cycles
      wait_rise(0, 20, cyc);
      wait_rise(0, 20, cyc);
      check("busclk_period", cyc, 4);
      wait_rise(5, 200, cyc);
      check("reach_search", link_state, 4'd2);

`ifdef PPB_PROBE_ID_CHECK_EN
      push_init(24'hABCDEF, 4, 4);
      wait_rise(3, 400, cyc);
      check("id_mismatch_fail", (cyc > 0), 1'b1);
      check("id_mismatch_state", link_state, 4'd2);
      exp_id = 24'h123456;
`else
      exp_id = 24'hABCDEF;
`endif

      // Nominal init and 4-block frames
      push_init(exp_id, 4, 4);
      wait_rise(1, 400, cyc);
      check("nom_ack_seen", (cyc > 0), 1'b1);
      check("nom_link_up", link_up, 1'b1);
      check("nom_state", link_state, 4'd5);
      check("nom_project_id", project_id, exp_id);
      check("nom_in_blocks", in_blocks, 9'd4);
      check("nom_out_blocks", out_blocks, 9'd4);
      wait_rise(2, 100, cyc);
      check("nom_first_fv_delay", cyc, 32);
      wait_rise(2, 100, cyc);
      check("nom_fv_period", cyc, 16);
      check("nom_probe_outputs", probe_outputs, {12'o7654, 36'h0});
      check("nom_ack_gap", t_ack_gap, 2);
      check("nom_ctrl_gap", t_ctrl_gap, 4);
      check("nom_target_rx", {t_rx[0], t_rx[1], t_rx[2], t_rx[3]}, 12'o1234);

      // Reset mid-frame
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("midrst_pins", {bus_if.pmod_bus_clk, bus_if.pmod_bus_control, bus_if.pmod_bus_poti}, 5'b0);
      check("midrst_outputs", probe_outputs, 48'h0);
      check("midrst_misc", {frame_valid, link_up, init_fail, link_state, project_id, in_blocks, out_blocks}, 49'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_settle", link_state, 4'd1);

      // Asymmetric counts: IB=2, OB=5
      wait_rise(5, 200, cyc);
      check("asym_search", link_state, 4'd2);
      push_init(exp_id, 2, 5);
      wait_rise(4, 400, cyc);
      check("asym_link_up", (cyc > 0), 1'b1);
      wait_rise(2, 100, cyc);
      check("asym_first_fv_delay", cyc, 40);
      wait_rise(2, 100, cyc);
      check("asym_fv_period", cyc, 20);
      check("asym_probe_outputs", probe_outputs, {15'o76543, 33'h0});
      check("asym_ctrl_gap", t_ctrl_gap, 5);
      check("asym_target_rx", {t_rx[0], t_rx[1]}, 6'o12);
      check("asym_poti_idle_zero", t_poti_nz, 1'b0);

      // Bad block counts, then relock
      pulse_reset();
      wait_rise(5, 200, cyc);
      check("bad_search", link_state, 4'd2);
      c0 = ctrl_cnt;
      push_init(exp_id, 4, 0);
      wait_rise(3, 400, cyc);
      check("bad_ob0_fail", (cyc > 0), 1'b1);
      check("bad_ob0_state", link_state, 4'd2);
      push_init(exp_id, 4, 17);
      wait_rise(3, 400, cyc);
      check("bad_ob17_fail", (cyc > 0), 1'b1);
      repeat (8) @(posedge clk);
      #1;
      check("bad_no_control", ctrl_cnt - c0, 0);
      check("bad_not_active", link_up, 1'b0);
      push_init(exp_id, 3, 3);
      wait_rise(4, 400, cyc);
      check("relock_link_up", (cyc > 0), 1'b1);
      check("relock_counts", {in_blocks, out_blocks}, {9'd3, 9'd3});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
